// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: pops raw bytes from the receiver, folds E0/F0/E1
// prefixes into single key events and queues them in a show-ahead event FIFO.
`timescale 1ns/1ps
module ps2_scancode_decoder #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kbd_ready,
    input  logic [7:0]                 kbd_data,
    output logic                       kbd_read_enable,
    output logic                       evt_valid,
    output logic [7:0]                 evt_code,
    output logic                       evt_break,
    output logic                       evt_ext,
    input  logic                       evt_pop,
    output logic [$clog2(DEPTH):0]     evt_count,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     byte_q, byte_d;
    logic           kbd_re_q, kbd_re_d;
    logic [2:0]     skip_q, skip_d;
    logic           ext_pend_q, ext_pend_d;
    logic           brk_pend_q, brk_pend_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    logic           push;
    logic [9:0]     push_entry;
    logic           pop_ok;
    logic           full;
    logic           do_push;
    logic [9:0]     mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            kbd_re_q   <= 1'b0;
            skip_q     <= 3'd0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            kbd_re_q   <= kbd_re_d;
            skip_q     <= skip_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        kbd_re_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (kbd_ready) begin
                    byte_d   = kbd_data;
                    kbd_re_d = 1'b1;
                    state_d  = POP;
                end
            end
            POP:     state_d = DECODE;
            DECODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode rules in priority order; only the DECODE state acts on byte_q.
    always_comb begin
        push       = 1'b0;
        push_entry = {ext_pend_q, brk_pend_q, byte_q};
        skip_d     = skip_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        if (state_q == DECODE) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (byte_q == 8'hE1) begin
                skip_d     = 3'd7;
                push       = 1'b1;
                push_entry = {1'b1, 1'b0, 8'h77};
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else if (byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else if ((byte_q == 8'hAA || byte_q == 8'hFA || byte_q == 8'hFE ||
                          byte_q == 8'hEE) && !ext_pend_q && !brk_pend_q) begin
                push = 1'b0;
            end else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    // A push into a full FIFO is accepted only when a real pop frees a slot.
    always_comb begin
        full       = (count_q == FULL_CNT);
        pop_ok     = evt_pop && (count_q != '0);
        do_push    = push && (!full || pop_ok);
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (do_push && !pop_ok)      count_d = count_q + 1'b1;
        else if (!do_push && pop_ok) count_d = count_q - 1'b1;
        overflow_d = overflow_q;
        if (push && !do_push)  overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;
    end

    // NOTE: the storage array carries no reset; pointers and count define which
    // entries are meaningful, so clearing the data would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_entry;
    end

    assign {evt_ext, evt_break, evt_code} = mem[rd_ptr_q];
    assign kbd_read_enable = kbd_re_q;
    assign evt_valid       = (count_q != '0);
    assign evt_count       = count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events are queued as bytes
// are sent and compared as the CPU side drains the FIFO.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kbd_ready = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_read_enable;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       evt_pop = 1'b0;
    logic [3:0] evt_count;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int re_pulses = 0;
    logic [9:0] exp_q[$];

    ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .kbd_ready(kbd_ready), .kbd_data(kbd_data), .kbd_read_enable(kbd_read_enable),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
        .evt_pop(evt_pop), .evt_count(evt_count),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (kbd_read_enable) re_pulses++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model: present a byte, hold it until the pop strobe, then withdraw.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        kbd_data  = b;
        kbd_ready = 1'b1;
        for (int i = 0; i < 10 && !kbd_read_enable; i++) @(negedge clk);
        if (!kbd_read_enable) check("read_enable_timeout", kbd_read_enable, 1'b1);
        kbd_ready = 1'b0;
        @(negedge clk);
        if (kbd_read_enable) check("read_enable_width", kbd_read_enable, 1'b0);
    endtask

    task automatic send_event(input logic [7:0] code, input logic ext, input logic brk);
        if (ext) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_byte(code);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic pop_one(input string tag);
        logic [9:0] exp;
        for (int i = 0; i < 40 && !evt_valid; i++) @(negedge clk);
        check({tag, "_valid"}, evt_valid, 1'b1);
        exp = exp_q.pop_front();
        check({tag, "_event"}, {evt_ext, evt_break, evt_code}, exp);
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        while (exp_q.size() != 0) pop_one(tag);
        @(negedge clk);
        check({tag, "_empty"}, evt_valid, 1'b0);
        check({tag, "_count0"}, evt_count, 4'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, evt_valid, 1'b0);
        check({tag, "_count"}, evt_count, 4'd0);
        check({tag, "_ovf"}, overflow, 1'b0);
        check({tag, "_re"}, kbd_read_enable, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single make code, with cycle-accurate strobe and latency checks.
        @(negedge clk);
        p0 = re_pulses;
        kbd_data  = 8'h1C;
        kbd_ready = 1'b1;
        @(negedge clk);
        check("t1_re_pop", kbd_read_enable, 1'b1);
        kbd_ready = 1'b0;
        @(negedge clk);
        check("t1_re_low", kbd_read_enable, 1'b0);
        check("t1_not_yet", evt_valid, 1'b0);
        @(negedge clk);
        check("t1_latency3", evt_valid, 1'b1);
        check("t1_count1", evt_count, 4'd1);
        repeat (3) @(negedge clk);
        check("t1_re_pulses", re_pulses - p0, 16'd1);
        exp_q.push_back({1'b0, 1'b0, 8'h1C});
        drain("t1");

        // Extended break: E0 F0 75, prefixes must not yield events.
        send_byte(8'hE0);
        send_byte(8'hF0);
        repeat (3) @(negedge clk);
        check("t2_no_prefix_evt", evt_count, 4'd0);
        send_byte(8'h75);
        exp_q.push_back({1'b1, 1'b1, 8'h75});
        drain("t2");

        // Pause sequence swallows its 7 trailing bytes, then a normal key.
        send_byte(8'hE1);
        exp_q.push_back({1'b1, 1'b0, 8'h77});
        send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_event(8'h1C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_count2", evt_count, 4'd2);
        drain("t3");

        // Status byte alone is dropped; after F0 it is a real break code.
        send_byte(8'hFA);
        repeat (3) @(negedge clk);
        check("t4_fa_dropped", evt_count, 4'd0);
        send_event(8'hAA, 1'b0, 1'b1);
        drain("t4");

        // Overflow: nine make codes into eight slots.
        for (int k = 1; k <= 9; k++) begin
            send_byte(8'(k));
            if (k <= DEPTH) exp_q.push_back({2'b00, 8'(k)});
        end
        repeat (4) @(negedge clk);
        check("t5_full_count", evt_count, 4'd8);
        check("t5_overflow", overflow, 1'b1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("t5_ovf_clr", overflow, 1'b0);

        // Push and pop in the same cycle while full: count stays at DEPTH.
        @(negedge clk);
        kbd_data  = 8'h0A;
        kbd_ready = 1'b1;
        @(negedge clk);
        kbd_ready = 1'b0;
        @(negedge clk);
        check("t5_head_before", {evt_ext, evt_break, evt_code}, exp_q.pop_front());
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
        exp_q.push_back({2'b00, 8'h0A});
        check("t5_full_pushpop", evt_count, 4'd8);
        check("t5_no_ovf", overflow, 1'b0);
        drain("t5");

        // Randomised mix of make/break/extended keys against the scoreboard.
        for (int k = 0; k < 6; k++)
            send_event(8'($urandom_range(1, 126)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        drain("t6");

        // Reset mid-sequence: queued event and pending E0 are both lost.
        send_byte(8'h1C);
        send_byte(8'hE0);
        #3 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t7_rst_a");
        @(negedge clk);
        check_reset_outputs("t7_rst_b");
        rst = 1'b0;
        send_event(8'h6B, 1'b0, 1'b0);
        drain("t7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
